// File: rtl/imem_arbiter.sv
// imem_arbiter: round-robin sharing of the instruction-memory read port between fetch and debug
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   if_req/if_addr              fetch request and byte address, held until if_gnt
//   if_gnt/if_rvalid            fetch grant pulse, response-valid pulse
//   if_rdata/if_err             fetch response word and fault flag (held between responses)
//   dbg_req/dbg_addr            debug request and byte address, held until dbg_gnt
//   dbg_gnt/dbg_rvalid          debug grant pulse, response-valid pulse
//   dbg_rdata/dbg_err           debug response word and fault flag (held between responses)
//   mem_a/mem_r/mem_rd          memory byte address, read enable, combinational read data
module imem_arbiter #(
  parameter int DEPTH_WORDS = 2048,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  output logic              if_err,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [31:0]       dbg_rdata,
  output logic              dbg_err,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_r,
  input  logic [31:0]       mem_rd
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              own_dbg_q, own_dbg_d;
  logic              fault_q, fault_d;
  logic              last_dbg_q, last_dbg_d;
  logic [31:0]       if_rdata_q, if_rdata_d, dbg_rdata_q, dbg_rdata_d;
  logic              if_err_q, if_err_d, dbg_err_q, dbg_err_d;
  logic              gnt_if, gnt_dbg, gnt_any;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       resp_data;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      own_dbg_q   <= 1'b0;
      fault_q     <= 1'b0;
      last_dbg_q  <= 1'b1;
      if_rdata_q  <= '0;
      if_err_q    <= 1'b0;
      dbg_rdata_q <= '0;
      dbg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      own_dbg_q   <= own_dbg_d;
      fault_q     <= fault_d;
      last_dbg_q  <= last_dbg_d;
      if_rdata_q  <= if_rdata_d;
      if_err_q    <= if_err_d;
      dbg_rdata_q <= dbg_rdata_d;
      dbg_err_q   <= dbg_err_d;
    end
  end
  // On a tie the requester that was not served last wins.
  always_comb begin
    gnt_if   = (state_q != ACCESS) && if_req && (!dbg_req || last_dbg_q);
    gnt_dbg  = (state_q != ACCESS) && dbg_req && !gnt_if;
    gnt_any  = gnt_if || gnt_dbg;
    sel_addr = gnt_dbg ? dbg_addr : if_addr;
    state_d  = (state_q == ACCESS) ? RESP : gnt_any ? ACCESS : IDLE;
  end
  // The fault verdict is taken at grant time and travels with the transaction.
  always_comb begin
    addr_d      = gnt_any ? sel_addr : addr_q;
    own_dbg_d   = gnt_any ? gnt_dbg : own_dbg_q;
    last_dbg_d  = gnt_any ? gnt_dbg : last_dbg_q;
    fault_d     = gnt_any ? ((|sel_addr[1:0]) || ((sel_addr >> 2) >= ADDR_W'(DEPTH_WORDS))) : fault_q;
    resp_data   = fault_q ? 32'h0 : mem_rd;
    if_rdata_d  = (state_q == ACCESS && !own_dbg_q) ? resp_data : if_rdata_q;
    if_err_d    = (state_q == ACCESS && !own_dbg_q) ? fault_q : if_err_q;
    dbg_rdata_d = (state_q == ACCESS && own_dbg_q) ? resp_data : dbg_rdata_q;
    dbg_err_d   = (state_q == ACCESS && own_dbg_q) ? fault_q : dbg_err_q;
  end
  // Grants are masked by rst_n so they drop the moment reset is applied.
  always_comb begin
    mem_r      = (state_q == ACCESS) && !fault_q;
    mem_a      = mem_r ? addr_q : '0;
    if_gnt     = gnt_if && rst_n;
    dbg_gnt    = gnt_dbg && rst_n;
    if_rvalid  = (state_q == RESP) && !own_dbg_q;
    dbg_rvalid = (state_q == RESP) && own_dbg_q;
    if_rdata   = if_rdata_q;
    if_err     = if_err_q;
    dbg_rdata  = dbg_rdata_q;
    dbg_err    = dbg_err_q;
  end
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: self-checking bench for imem_arbiter with a response scoreboard
module tb_imem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0, dbg_req = 1'b0;
  logic [31:0] if_addr = '0, dbg_addr = '0;
  logic        if_gnt, if_rvalid, if_err, dbg_gnt, dbg_rvalid, dbg_err, mem_r;
  logic [31:0] if_rdata, dbg_rdata, mem_a, mem_rd;
  logic [31:0] mem [2048];
  int          n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  assign mem_rd = mem[mem_a[12:2]];
  imem_arbiter #(.DEPTH_WORDS(2048), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
    .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
    .mem_a(mem_a), .mem_r(mem_r), .mem_rd(mem_rd)
  );
  typedef struct {logic [31:0] data; logic err; int due;} exp_t;
  typedef struct {bit d; logic [31:0] a; logic [31:0] data; logic err;} vec_t;
  exp_t if_q[$], dbg_q[$];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", n, act, exp);
    end
  endtask
  task automatic chkb(input string n, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", n, act, exp);
    end
  endtask
  function automatic exp_t model(input logic [31:0] a, input int due);
    exp_t e;
    e.err  = (a[1:0] != 2'b00) || (a[31:2] >= 30'd2048);
    e.data = e.err ? 32'h0 : (a[12:2] == 11'd3) ? 32'h20080005 : 32'h10000000 + {21'b0, a[12:2]};
    e.due  = due;
    return e;
  endfunction
  initial begin
    int          cyc = 0;
    logic        exp_mr = 1'b0;
    logic [31:0] exp_ma = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        if_q.delete();
        dbg_q.delete();
        exp_mr = 1'b0;
        exp_ma = '0;
      end else begin
        chkb("mem_r", mem_r, exp_mr);
        chk("mem_a", mem_a, exp_ma);
        chkb("single_gnt", if_gnt & dbg_gnt, 1'b0);
        exp_mr = 1'b0;
        exp_ma = '0;
        if (if_gnt) begin
          e = model(if_addr, cyc + 2);
          if_q.push_back(e);
          exp_mr = !e.err;
          exp_ma = e.err ? 32'h0 : if_addr;
        end
        if (dbg_gnt) begin
          e = model(dbg_addr, cyc + 2);
          dbg_q.push_back(e);
          exp_mr = !e.err;
          exp_ma = e.err ? 32'h0 : dbg_addr;
        end
        if (if_rvalid) begin
          if (if_q.size() == 0) chkb("if_rvalid_unexpected", 1'b1, 1'b0);
          else begin
            e = if_q.pop_front();
            chk("if_rdata", if_rdata, e.data);
            chkb("if_err", if_err, e.err);
            chk("if_latency", 32'(cyc), 32'(e.due));
          end
        end else if (if_q.size() > 0 && if_q[0].due <= cyc) begin
          chkb("if_rvalid_missing", 1'b0, 1'b1);
          void'(if_q.pop_front());
        end
        if (dbg_rvalid) begin
          if (dbg_q.size() == 0) chkb("dbg_rvalid_unexpected", 1'b1, 1'b0);
          else begin
            e = dbg_q.pop_front();
            chk("dbg_rdata", dbg_rdata, e.data);
            chkb("dbg_err", dbg_err, e.err);
            chk("dbg_latency", 32'(cyc), 32'(e.due));
          end
        end else if (dbg_q.size() > 0 && dbg_q[0].due <= cyc) begin
          chkb("dbg_rvalid_missing", 1'b0, 1'b1);
          void'(dbg_q.pop_front());
        end
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  task automatic wait_gnt(input bit d);
    bit got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = d ? dbg_gnt : if_gnt;
      if (!got) begin
        @(posedge clk);
        #1;
      end
    end
    chkb("gnt_timeout", got, 1'b1);
  endtask
  task automatic txn(input bit d, input logic [31:0] a, output logic rv, output logic [31:0] rd,
                     output logic er);
    if (d) begin
      dbg_req = 1'b1;
      dbg_addr = a;
    end else begin
      if_req = 1'b1;
      if_addr = a;
    end
    wait_gnt(d);
    @(posedge clk);
    #1;
    if_req = 1'b0;
    dbg_req = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rv = d ? dbg_rvalid : if_rvalid;
    rd = d ? dbg_rdata : if_rdata;
    er = d ? dbg_err : if_err;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_all_zero(input string n);
    chk({n, "_rdata"}, if_rdata | dbg_rdata, 32'h0);
    chk({n, "_mem_a"}, mem_a, 32'h0);
    chk({n, "_flags"}, 32'({if_gnt, if_rvalid, if_err, dbg_gnt, dbg_rvalid, dbg_err, mem_r}), 32'h0);
  endtask
  initial begin
    vec_t        vt[8];
    logic        rv, er;
    logic [31:0] rd;
    for (int i = 0; i < 2048; i++) mem[i] = 32'h10000000 + 32'(i);
    mem[3] = 32'h20080005;
    vt[0] = '{0, 32'h0000000C, 32'h20080005, 1'b0};
    vt[1] = '{1, 32'h00000006, 32'h00000000, 1'b1};
    vt[2] = '{0, 32'h00002000, 32'h00000000, 1'b1};
    vt[3] = '{0, 32'h00001FFC, 32'h100007FF, 1'b0};
    vt[4] = '{1, 32'h00001FFC, 32'h100007FF, 1'b0};
    vt[5] = '{1, 32'h00000004, 32'h10000001, 1'b0};
    vt[6] = '{0, 32'h00000003, 32'h00000000, 1'b1};
    vt[7] = '{0, 32'hFFFFFFFC, 32'h00000000, 1'b1};
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      txn(vt[i].d, vt[i].a, rv, rd, er);
      chkb($sformatf("vec%0d_rvalid", i), rv, 1'b1);
      chk($sformatf("vec%0d_rdata", i), rd, vt[i].data);
      chkb($sformatf("vec%0d_err", i), er, vt[i].err);
    end
    rst_n = 1'b0;
    if_req = 1'b1;
    if_addr = 32'h0;
    dbg_req = 1'b1;
    dbg_addr = 32'h4;
    @(posedge clk);
    #1;
    chk_all_zero("cont_reset");
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chkb($sformatf("cont%0d_if_gnt", k), if_gnt, k % 4 == 0);
      chkb($sformatf("cont%0d_dbg_gnt", k), dbg_gnt, k % 4 == 2);
      @(posedge clk);
      #1;
    end
    if_req = 1'b0;
    dbg_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    if_req = 1'b1;
    if_addr = 32'h10;
    wait_gnt(1'b0);
    @(posedge clk);
    #1;
    if_req = 1'b0;
    chkb("mid_access_mem_r", mem_r, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chkb("post_reset_if_rvalid", if_rvalid, 1'b0);
      @(posedge clk);
      #1;
    end
    txn(0, 32'h10, rv, rd, er);
    chkb("fresh_rvalid", rv, 1'b1);
    chk("fresh_rdata", rd, 32'h10000004);
    chkb("fresh_err", er, 1'b0);
    dbg_req = 1'b1;
    dbg_addr = 32'h8;
    for (int k = 0; k < 12; k++) begin
      if (k == 1) begin
        if_req = 1'b1;
        if_addr = 32'h14;
      end
      if (k == 2) if_req = 1'b0;
      @(negedge clk);
      chkb($sformatf("b2b%0d_dbg_gnt", k), dbg_gnt, k % 2 == 0);
      chkb($sformatf("b2b%0d_if_gnt", k), if_gnt, 1'b0);
      chkb($sformatf("b2b%0d_dbg_rvalid", k), dbg_rvalid, k >= 2 && k % 2 == 0);
      chkb($sformatf("b2b%0d_if_rvalid", k), if_rvalid, 1'b0);
      @(posedge clk);
      #1;
    end
    dbg_req = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(if_q.size() + dbg_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
